// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one fixed-latency single-port memory
//            between instruction fetch and load/store; one access in flight.
//            Optional perf counters enabled by defining MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [31:0]       ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    input  logic [3:0]        ls_be_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [31:0]       ls_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_if_gnt_o,
    output logic [31:0]       perf_ls_gnt_o,
    output logic [31:0]       perf_stall_o,
`endif
    input  logic [31:0]       mem_rdata_i
);

    localparam int              c_cnt_w   = $clog2(MEM_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_lat  = c_cnt_w'(MEM_LAT);
    localparam logic [0:0]      c_st_idle = 1'b0;
    localparam logic [0:0]      c_st_wait = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               last_q, last_d;     // 0 = IF won last, 1 = LS won last
    logic               win_ls_q, win_ls_d;
    logic               store_q, store_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               ls_rvalid_q, ls_rvalid_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        ls_rdata_q, ls_rdata_d;

    logic               any_req;
    logic               sel_ls;
    logic               unused_addr_bits;

    assign any_req = if_req_i | ls_req_i;
    // On a tie the port that did not win last time takes the slot.
    assign sel_ls  = ls_req_i & (~if_req_i | ~last_q);

    // Only address bits [ADDR_W+1:2] reach the memory.
    assign unused_addr_bits = ^{if_addr_i, ls_addr_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= c_st_idle;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            win_ls_q    <= 1'b0;
            store_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            win_ls_q    <= win_ls_d;
            store_q     <= store_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        win_ls_d    = win_ls_q;
        store_d     = store_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            c_st_idle: begin
                if (any_req) begin
                    state_d  = c_st_wait;
                    cnt_d    = c_cnt_w'(1);
                    last_d   = sel_ls;
                    win_ls_d = sel_ls;
                    store_d  = sel_ls & ls_we_i;
                end
            end
            c_st_wait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_lat) begin
                    state_d = c_st_idle;
                    if (win_ls_q) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = store_q ? 32'h0 : mem_rdata_i;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata_i;
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (state_q == c_st_idle && any_req) begin
            mem_en_o = 1'b1;
            if (sel_ls) begin
                ls_gnt_o    = 1'b1;
                mem_we_o    = ls_we_i;
                mem_addr_o  = ls_addr_i[ADDR_W+1:2];
                mem_wdata_o = ls_wdata_i;
                mem_be_o    = ls_be_i;
            end else begin
                if_gnt_o    = 1'b1;
                mem_addr_o  = if_addr_i[ADDR_W+1:2];
                mem_be_o    = 4'hF;
            end
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_rdata_o  = ls_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_ls_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_if_q    <= '0;
            perf_ls_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (if_gnt_o)                              perf_if_q    <= perf_if_q + 32'd1;
            if (ls_gnt_o)                              perf_ls_q    <= perf_ls_q + 32'd1;
            if (any_req && !(if_gnt_o || ls_gnt_o))    perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_if_gnt_o = perf_if_q;
    assign perf_ls_gnt_o = perf_ls_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MEM_LAT = 2;
    localparam int ADDR_W  = 16;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_gnt_o, if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              ls_req_i, ls_we_i;
    logic [31:0]       ls_addr_i, ls_wdata_i;
    logic [3:0]        ls_be_i;
    logic              ls_gnt_o, ls_rvalid_o;
    logic [31:0]       ls_rdata_o;
    logic              mem_en_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_if_gnt_o, perf_ls_gnt_o, perf_stall_o;
`endif

    mem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_be_i     (ls_be_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
`ifdef MEM_ARB_PERF_EN
        .perf_if_gnt_o (perf_if_gnt_o),
        .perf_ls_gnt_o (perf_ls_gnt_o),
        .perf_stall_o  (perf_stall_o),
`endif
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit tmo   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h0051_3093 : (32'hA5A5_0000 ^ (i * 32'h0101_0101));
    endfunction

    // Memory macro: 16 words, data appears MEM_LAT cycles after the strobe.
    logic [31:0] mem_env [16];
    logic [31:0] pipe    [MEM_LAT];
    assign mem_rdata_i = pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) mem_env[i] <= init_word(i);
        end else if (mem_en_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem_env[mem_addr_o[3:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        pipe[0] <= (mem_en_o && !mem_we_o) ? mem_env[mem_addr_o[3:0]] : $urandom;
        for (int k = MEM_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    end

    // Reference model: a slot frees MEM_LAT+1 cycles after a grant; ties go
    // to the port that did not win last; responses come due at grant+MEM_LAT+1.
    typedef struct {
        bit          port;   // 1 = LS
        logic [31:0] data;
        int          due;
    } resp_t;
    resp_t       exp_q[$];
    logic [31:0] ref_mem [16];
    int          next_free;
    bit          last_ls;
    int          pf_if, pf_ls, pf_st;
    bit          free, e_ig, e_lg, st;
    logic [31:0] a;
    resp_t       r;

    always @(negedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            exp_q.delete();
            next_free = 0;
            last_ls   = 1'b0;
            pf_if = 0; pf_ls = 0; pf_st = 0;
            chk("rst_if_gnt", if_gnt_o, 0);
            chk("rst_ls_gnt", ls_gnt_o, 0);
            chk("rst_mem_en", mem_en_o, 0);
`ifdef MEM_ARB_PERF_EN
            chk("rst_perf_if", perf_if_gnt_o, 0);
            chk("rst_perf_ls", perf_ls_gnt_o, 0);
            chk("rst_perf_stall", perf_stall_o, 0);
`endif
        end else begin
            free = (cyc >= next_free);
            e_ig = free && if_req_i && !(ls_req_i && !last_ls);
            e_lg = free && ls_req_i && !(if_req_i && last_ls);
            chk("if_gnt", if_gnt_o, e_ig);
            chk("ls_gnt", ls_gnt_o, e_lg);
`ifdef MEM_ARB_PERF_EN
            chk("perf_if", perf_if_gnt_o, pf_if);
            chk("perf_ls", perf_ls_gnt_o, pf_ls);
            chk("perf_stall", perf_stall_o, pf_st);
`endif
            pf_if += int'(e_ig);
            pf_ls += int'(e_lg);
            pf_st += int'((if_req_i || ls_req_i) && !(e_ig || e_lg));
            if (e_ig || e_lg) begin
                a  = e_lg ? ls_addr_i : if_addr_i;
                st = e_lg && ls_we_i;
                chk("mem_en", mem_en_o, 1);
                chk("mem_we", mem_we_o, st);
                chk("mem_addr", mem_addr_o, a[17:2]);
                chk("mem_be", mem_be_o, e_lg ? ls_be_i : 4'hF);
                if (e_lg) chk("mem_wdata", mem_wdata_o, ls_wdata_i);
                r.port = e_lg;
                r.due  = cyc + MEM_LAT + 1;
                r.data = st ? 32'h0 : ref_mem[a[5:2]];
                if (st)
                    for (int b = 0; b < 4; b++)
                        if (ls_be_i[b]) ref_mem[a[5:2]][8*b +: 8] = ls_wdata_i[8*b +: 8];
                exp_q.push_back(r);
                next_free = cyc + MEM_LAT + 1;
                last_ls   = e_lg;
            end else begin
                chk("idle_mem_en", mem_en_o, 0);
                chk("idle_mem_we", mem_we_o, 0);
                chk("idle_mem_addr", mem_addr_o, 0);
                chk("idle_mem_wdata", mem_wdata_o, 0);
                chk("idle_mem_be", mem_be_o, 0);
            end
        end
    end

    // Response monitor: pops the scoreboard when a response comes due.
    logic [31:0] hold_if = 32'h0, hold_ls = 32'h0;
    bit          ev_if, ev_ls;

    always @(negedge clk) begin
        ev_if = 1'b0;
        ev_ls = 1'b0;
        if (!rst_ni) begin
            hold_if = 32'h0;
            hold_ls = 32'h0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].port) begin ev_ls = 1'b1; hold_ls = exp_q[0].data; end
            else               begin ev_if = 1'b1; hold_if = exp_q[0].data; end
            void'(exp_q.pop_front());
        end
        chk("if_rvalid", if_rvalid_o, ev_if);
        chk("ls_rvalid", ls_rvalid_o, ev_ls);
        chk("if_rdata", if_rdata_o, hold_if);
        chk("ls_rdata", ls_rdata_o, hold_ls);
        chk("drain_timeout", tmo, 0);
    end

    // Stimulus
    logic gi, gl;

    task automatic step();
        @(negedge clk);
        gi = if_gnt_o;
        gl = ls_gnt_o;
        @(posedge clk);
        #1;
        if (gi) if_req_i = 1'b0;
        if (gl) ls_req_i = 1'b0;
    endtask

    task automatic start_if(input logic [31:0] addr);
        if_req_i  = 1'b1;
        if_addr_i = addr;
    endtask

    task automatic start_ls(input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be);
        ls_req_i   = 1'b1;
        ls_we_i    = we;
        ls_addr_i  = addr;
        ls_wdata_i = wd;
        ls_be_i    = be;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            step();
            if (!if_req_i && !ls_req_i && exp_q.size() == 0) return;
        end
        tmo = 1'b1;
    endtask

    task automatic do_reset();
        rst_ni   = 1'b0;
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    localparam logic [31:0] c_amask = 32'hFFFC_003F;

    initial begin
        rst_ni = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // First tie after reset, then a second tie
        start_if(32'h0000_0100); start_ls(1'b0, 32'h20, 32'h0, 4'hF);
        drain();
        start_if(32'h0000_0104); start_ls(1'b0, 32'h24, 32'h0, 4'h0);
        drain();

        // Single fetch, store with partial byte enables, load back
        start_if(32'h0000_0010);
        drain();
        start_ls(1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0011);
        drain();
        start_ls(1'b0, 32'hC000_0046, 32'h0, 4'h0);
        drain();

        // Both ports requesting continuously
        do_reset();
        start_if(32'h8); start_ls(1'b0, 32'hC, 32'h0, 4'hF);
        repeat (12) begin
            step();
            if (!if_req_i) start_if($urandom & c_amask);
            if (!ls_req_i) start_ls(1'b0, $urandom & c_amask, 32'h0, 4'hF);
        end
        drain();

        // Random traffic
        repeat (400) begin
            step();
            if (!if_req_i && $urandom_range(0, 2) == 0) start_if($urandom & c_amask);
            if (!ls_req_i && $urandom_range(0, 2) == 0)
                start_ls(1'($urandom_range(0, 1)), $urandom & c_amask, $urandom, 4'($urandom));
        end
        drain();

        // Reset in the first WAIT cycle drops the in-flight response
        start_if(32'h0000_0010);
        step();
        do_reset();
        repeat (10) step();

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
